isb_train_unit: RTL and testbench

//  Parametrised training unit for the ISB prefetcher. Keeps per-PC last-address history
//  in a direct-mapped, PC-tagged table. Each in-order access on a trained PC emits a

---
 rtl/isb_train_unit_pkg.sv | 21 ++
 rtl/isb_train_unit_pair_fifo.sv | 74 +++++++
 rtl/isb_train_unit.sv | 161 ++++++++++++++++
 tb/tb_isb_train_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/isb_train_unit_pkg.sv
// Shared definitions for the ISB training unit.
//   STAT_W / STAT_MAX : statistics counter width and saturation value
//   acc_kind_e        : classification of one access against the history table
//   sat_inc           : saturating increment for the statistics counters
package isb_train_unit_pkg;

    localparam int                STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ACC_NONE   = 2'd0,  // no valid access this cycle
        ACC_MISS   = 2'd1,  // entry invalid or tag mismatch: (re)allocate
        ACC_REPEAT = 2'd2,  // hit, same address as last: filtered
        ACC_PAIR   = 2'd3   // hit, new address: emit (last, addr)
    } acc_kind_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/isb_train_unit_pair_fifo.sv
// isb_pair_fifo: synchronous FIFO for correlated address pairs.
// The head entry is read straight from the storage flops, so a push into
// an empty FIFO is visible on head_data/empty right after that edge.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write request (ignored when full unless popping)
//   pop                 consume head (ignored when empty)
//   full, empty         occupancy flags
//   head_data           oldest entry; zero after reset
// DEPTH must be a power of two so pointers wrap naturally.
module isb_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_MAX = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_MAX);
    assign head_data = mem_q[rd_ptr_q];

    // When full, a same-edge pop frees the head slot, which is exactly the
    // slot wr_ptr points at, so the write lands in the freed slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/isb_train_unit.sv
// isb_train_unit: ISB prefetcher training unit.
// Keeps a direct-mapped, PC-tagged table of the last address seen per PC.
// A hit with a new address emits (last, addr) into a pair FIFO; a hit with
// the same address is filtered; a miss (re)allocates the entry.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   v_in, pc, addr                 access stream, one access per cycle
//   pair_v, pair_prev, pair_curr   FIFO head
//   pair_rdy                       consumer accepts head on pair_v && pair_rdy
//   stat_hits, stat_drops          saturating statistics
// Build option: define ISB_TU_STATS_EN to enable the hit/drop counters;
// otherwise both outputs are tied to zero and no counter flops exist.
module isb_train_unit
    import isb_train_unit_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int ADDR_W     = 16,
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_in,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] addr,
    output logic              pair_v,
    output logic [ADDR_W-1:0] pair_prev,
    output logic [ADDR_W-1:0] pair_curr,
    input  logic              pair_rdy,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_drops
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_d  [ENTRIES];
    logic [ADDR_W-1:0]  last_q [ENTRIES];
    logic [ADDR_W-1:0]  last_d [ENTRIES];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                ent_hit;
    acc_kind_e           kind;
    logic                want_push;
    logic                push_ok;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*ADDR_W-1:0] push_data;
    logic [2*ADDR_W-1:0] head_data;

    assign idx     = pc[IDX_W-1:0];
    assign tag     = pc[PC_W-1:IDX_W];
    assign ent_hit = valid_q[idx] && (tag_q[idx] == tag);

    // Table state is read straight from the flops, so an access in cycle
    // N+1 always sees the update made at the end of cycle N.
    always_comb begin
        kind = ACC_NONE;
        if (v_in) begin
            if (!ent_hit)                kind = ACC_MISS;
            else if (addr == last_q[idx]) kind = ACC_REPEAT;
            else                         kind = ACC_PAIR;
        end
    end

    // Table updates regardless of whether the FIFO accepts the pair.
    always_comb begin
        valid_d = valid_q;
        for (int e = 0; e < ENTRIES; e++) begin
            tag_d[e]  = tag_q[e];
            last_d[e] = last_q[e];
        end
        case (kind)
            ACC_MISS: begin
                valid_d[idx] = 1'b1;
                tag_d[idx]   = tag;
                last_d[idx]  = addr;
            end
            ACC_PAIR: last_d[idx] = addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                tag_q[e]  <= '0;
                last_q[e] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int e = 0; e < ENTRIES; e++) begin
                tag_q[e]  <= tag_d[e];
                last_q[e] <= last_d[e];
            end
        end
    end

    assign want_push = (kind == ACC_PAIR);
    assign push_data = {last_q[idx], addr};
    assign pop       = pair_v && pair_rdy;
    assign push_ok   = !fifo_full || pop;

    isb_pair_fifo #(
        .WIDTH (2*ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (want_push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    assign pair_v    = !fifo_empty;
    assign pair_prev = head_data[2*ADDR_W-1:ADDR_W];
    assign pair_curr = head_data[ADDR_W-1:0];

`ifdef ISB_TU_STATS_EN
    logic [STAT_W-1:0] stat_hits_q, stat_hits_d;
    logic [STAT_W-1:0] stat_drops_q, stat_drops_d;
    logic              drop;

    assign drop = want_push && !push_ok;

    always_comb begin
        stat_hits_d  = stat_hits_q;
        stat_drops_d = stat_drops_q;
        if (kind == ACC_REPEAT || kind == ACC_PAIR) stat_hits_d = sat_inc(stat_hits_q);
        if (drop) stat_drops_d = sat_inc(stat_drops_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q  <= '0;
            stat_drops_q <= '0;
        end else begin
            stat_hits_q  <= stat_hits_d;
            stat_drops_q <= stat_drops_d;
        end
    end

    assign stat_hits  = stat_hits_q;
    assign stat_drops = stat_drops_q;
`else
    // push_ok only feeds the drop counter; the FIFO gates pushes itself.
    logic unused_push_ok;
    assign unused_push_ok = push_ok;
    assign stat_hits      = 16'h0000;
    assign stat_drops     = 16'h0000;
`endif

endmodule

// File: tb/tb_isb_train_unit.sv
module tb_isb_train_unit;

    localparam int PC_W  = 16;
    localparam int ADDR_W = 16;
    localparam int IDX_W = 3;
    localparam int DEPTH = 4;
    localparam int ENT   = 1 << IDX_W;
`ifdef ISB_TU_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              v_in;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic              pair_v;
    logic [ADDR_W-1:0] pair_prev, pair_curr;
    logic              pair_rdy;
    logic [15:0]       stat_hits, stat_drops;

    isb_train_unit #(.PC_W(PC_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .v_in(v_in), .pc(pc), .addr(addr),
        .pair_v(pair_v), .pair_prev(pair_prev), .pair_curr(pair_curr),
        .pair_rdy(pair_rdy), .stat_hits(stat_hits), .stat_drops(stat_drops)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-slot full PC + last address, a pair occupancy
    // count, and the queue of pairs the consumer should see in order.
    logic [31:0]       exp_q[$];
    bit                mv   [ENT];
    logic [PC_W-1:0]   mpc  [ENT];
    logic [ADDR_W-1:0] mlast[ENT];
    int                mcnt = 0;
    logic [15:0]       mhits = 0, mdrops = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares at the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("pair_v", 32'(pair_v), 32'(mcnt > 0));
        if (pair_v && pair_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pair_extra: got %h expected none", {pair_prev, pair_curr});
            end else begin
                check("pair_data", {pair_prev, pair_curr}, exp_q.pop_front());
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < ENT; i++) mv[i] = 1'b0;
        mcnt = 0;
        exp_q.delete();
        mhits = 0;
        mdrops = 0;
    endfunction

    // One access cycle; called #1 after a rising edge.
    task automatic step(bit v, logic [PC_W-1:0] p, logic [ADDR_W-1:0] a, bit rdy);
        int          i;
        bit          pop, push, acc;
        logic [31:0] pd;
        v_in = v; pc = p; addr = a; pair_rdy = rdy;
        i    = int'(p) % ENT;
        pop  = (mcnt > 0) && rdy;
        push = 1'b0;
        pd   = '0;
        if (v) begin
            if (!(mv[i] && mpc[i] == p)) begin
                mv[i] = 1'b1; mpc[i] = p; mlast[i] = a;
            end else begin
                if (mhits != 16'hFFFF) mhits++;
                if (a != mlast[i]) begin
                    push = 1'b1;
                    pd = {mlast[i], a};
                    mlast[i] = a;
                end
            end
        end
        acc = push && (mcnt < DEPTH || pop);
        if (push && !acc && mdrops != 16'hFFFF) mdrops++;
        @(posedge clk);
        mcnt = mcnt - int'(pop) + int'(acc);
        if (acc) exp_q.push_back(pd);
        #1;
    endtask

    task automatic idle(int n, bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, 16'($urandom), 16'($urandom), rdy);
    endtask

    task automatic check_stats(string tag);
        check({tag, "_hits"},  32'(stat_hits),  32'(STATS_EN ? mhits  : 16'h0));
        check({tag, "_drops"}, 32'(stat_drops), 32'(STATS_EN ? mdrops : 16'h0));
    endtask

    // Asynchronous reset pulse: pair_v must drop without waiting for a clock.
    task automatic pulse_reset();
        v_in = 1'b0;
        rst  = 1'b1;
        #1;
        model_clear();
        check("rst_pair_v", 32'(pair_v), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_in = 1'b0; pc = '0; addr = '0; pair_rdy = 1'b1;
        model_clear();
        #1;
        check("reset_pair_v", 32'(pair_v), 32'h0);
        check("reset_prev",   32'(pair_prev), 32'h0);
        check("reset_curr",   32'(pair_curr), 32'h0);
        check_stats("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: two accesses on pc 0 -> one pair
        step(1, 16'h0, 16'h10, 1);
        step(1, 16'h0, 16'h11, 1);
        idle(3, 1);

        // 2: repeat filter
        pulse_reset();
        step(1, 16'h0, 16'h10, 1);
        step(1, 16'h0, 16'h10, 1);
        step(1, 16'h0, 16'h12, 1);
        idle(3, 1);
        check_stats("t2");

        // 3: tag eviction re-trains, no pairs
        pulse_reset();
        step(1, 16'h0, 16'h10, 1);
        step(1, 16'h8, 16'h30, 1);
        step(1, 16'h0, 16'h20, 1);
        idle(3, 1);
        check("t3_pending", 32'(exp_q.size()), 32'h0);
        check_stats("t3");

        // 4: six pairs into a depth-4 FIFO with no consumer
        pulse_reset();
        step(1, 16'h0, 16'h0, 0);
        for (int k = 1; k <= 6; k++) step(1, 16'h0, 16'(k), 0);
        check_stats("t4_full");
        idle(6, 1);
        check("t4_pending", 32'(exp_q.size()), 32'h0);

        // 5: full FIFO, pop and push on the same edge
        pulse_reset();
        step(1, 16'h0, 16'h0, 0);
        for (int k = 1; k <= 4; k++) step(1, 16'h0, 16'(k), 0);
        step(1, 16'h0, 16'h5, 1);
        check_stats("t5");
        idle(4, 0);
        idle(5, 1);
        check("t5_pending", 32'(exp_q.size()), 32'h0);

        // 6: reset with pairs queued; next pc 0 access must be a miss
        pulse_reset();
        step(1, 16'h0, 16'h40, 0);
        for (int k = 1; k <= 3; k++) step(1, 16'h0, 16'(16'h40 + k), 0);
        pulse_reset();
        step(1, 16'h0, 16'h77, 1);
        idle(3, 1);
        check_stats("t6");

        // Random traffic: small PC and address sets force hits, repeats,
        // evictions and back-pressure.
        pulse_reset();
        for (int k = 0; k < 3000; k++)
            step(($urandom % 4) != 0, 16'($urandom % 24), 16'($urandom % 6), ($urandom % 3) != 0);
        idle(DEPTH + 2, 1);
        check("rand_pending", 32'(exp_q.size()), 32'h0);
        check_stats("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
